// File: rtl/ring_buffer.sv
// Single-clock circular-buffer FIFO for byte streams in the UART RPN datapath.
// Pops land in a registered output; `available` flags at least one unread word.
module ring_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             write_en,
    output logic [WIDTH-1:0] out,
    input  logic             read_en,
    output logic             available
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              empty, full, rd_acc, wr_acc;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_FULL);
        rd_acc   = read_en && !empty;
        // A read on a full buffer frees the slot this write lands in.
        wr_acc   = write_en && (!full || rd_acc);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        out_d    = out_q;

        if (rd_acc) begin
            out_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
        end
    end

    // Storage is intentionally not cleared by reset; only the pointers are.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= in;
        end
    end

    assign out       = out_q;
    assign available = !empty;

endmodule

// File: tb/tb_ring_buffer.sv
// Scoreboard bench for ring_buffer: stimulus queues expected pops, a monitor
// compares each word as it appears on `out`.
module tb_ring_buffer;

    logic       clk;
    logic       rst;
    logic [7:0] in;
    logic       write_en;
    logic [7:0] out;
    logic       read_en;
    logic       available;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic       pend;

    ring_buffer #(.WIDTH(8), .DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .write_en  (write_en),
        .out       (out),
        .read_en   (read_en),
        .available (available)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, got, want);
        end
    endtask

    // Apply inputs for the next rising edge, then return just after it.
    task automatic drive(input logic r, input logic we, input logic [7:0] d, input logic re);
        rst      = r;
        write_en = we;
        in       = d;
        read_en  = re;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input logic re, input logic keep);
        if (keep) exp_q.push_back(d);
        drive(1'b0, 1'b1, d, re);
    endtask

    // Monitor: decides at each negedge whether the coming edge pops, then
    // checks the popped word at the following negedge.
    initial begin
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got 0x%02h with no word expected", out);
                end else begin
                    check("pop_data", out, exp_q.pop_front());
                end
            end
            pend = read_en && available && !rst;
        end
    end

    initial begin
        rst = 1'b1; write_en = 1'b0; in = 8'h00; read_en = 1'b0;

        // Reset then idle reads on empty
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        check("reset_out", out, 8'h00);
        check("reset_avail", {7'b0, available}, 8'h00);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1);
            check("idle_out", out, 8'h00);
            check("idle_avail", {7'b0, available}, 8'h00);
        end

        // Basic order with overlapping reads
        wr(8'd10, 1'b0, 1'b1);
        check("first_write_avail", {7'b0, available}, 8'h01);
        wr(8'd9, 1'b0, 1'b1);
        wr(8'd8, 1'b0, 1'b1);
        wr(8'd7, 1'b0, 1'b1);
        wr(8'd6, 1'b1, 1'b1);
        wr(8'd5, 1'b1, 1'b1);
        wr(8'd4, 1'b1, 1'b1);
        wr(8'd3, 1'b1, 1'b1);
        wr(8'd2, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, (i % 2 == 0) ? 8'd1 : 8'd11, 1'b1);
        check("basic_avail_low", {7'b0, available}, 8'h00);
        check("basic_out_hold", out, 8'd2);

        // Fill to full, drop the 17th write, drain with one extra read
        for (int i = 0; i < 16; i++) wr(8'(i), 1'b0, 1'b1);
        wr(8'hAA, 1'b0, 1'b0);
        check("full_avail", {7'b0, available}, 8'h01);
        for (int i = 0; i < 17; i++) drive(1'b0, 1'b0, 8'h00, 1'b1);
        check("drain_out_hold", out, 8'h0F);
        check("drain_avail", {7'b0, available}, 8'h00);

        // Full with simultaneous read and write
        for (int i = 0; i < 16; i++) wr(8'h20 + 8'(i), 1'b0, 1'b1);
        wr(8'h55, 1'b1, 1'b1);
        check("full_rw_out", out, 8'h20);
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 8'h00, 1'b1);
        check("full_rw_last", out, 8'h55);
        check("full_rw_avail", {7'b0, available}, 8'h00);

        // Wrap-around: 10 rounds of 5 writes then 5 reads
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 5; k++) wr(8'(r * 5 + k + 1), 1'b0, 1'b1);
            for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 8'h00, 1'b1);
        end
        check("wrap_out", out, 8'd50);
        check("wrap_avail", {7'b0, available}, 8'h00);

        // Reset mid-operation discards stored words
        wr(8'hA1, 1'b0, 1'b1);
        wr(8'hA2, 1'b0, 1'b1);
        wr(8'hA3, 1'b0, 1'b1);
        exp_q.delete();
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        check("midrst_avail", {7'b0, available}, 8'h00);
        check("midrst_out", out, 8'h00);
        wr(8'h33, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        check("post_rst_out", out, 8'h33);
        check("post_rst_avail", {7'b0, available}, 8'h00);

        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_words: %0d queued words never popped, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_buffer.md
Name: ring_buffer

Overview:
- Synchronous single-clock FIFO built on a circular buffer, for byte streams in the UART RPN datapath, e.g. between the UART receiver and the command parser.
- Writes push bytes at the tail; reads pop the oldest byte into a registered output.
- `available` tells the consumer that at least one unread byte is stored.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of storage entries; must be a power of two and at least 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous active-high reset.
- in  input  WIDTH  write data; sampled on the clk edge when a write is accepted.
- write_en  input  1  write request, level-sensitive; one write per cycle while high.
- out  output  WIDTH  registered read data; holds the last popped word.
- read_en  input  1  read request, level-sensitive; one pop per cycle while high.
- available  output  1  high when the stored count is nonzero.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high: it acts only on a rising clk edge while rst=1.
- State: storage array mem[DEPTH], write pointer wr_ptr, read pointer rd_ptr, and count (0..DEPTH, ADDR_W+1 bits).
- On reset:
  - wr_ptr, rd_ptr and count go to 0.
  - out goes to 0.
  - available goes to 0.
  - mem contents are not cleared.
- Reset takes priority over read_en and write_en in the same cycle.
- A reset asserted mid-operation discards all stored data.
- Derived flags (combinational from count):
  - empty = (count==0)
  - full = (count==DEPTH)
  - available = !empty
- Read accepted: rd_acc = read_en && !empty.
- Write accepted: wr_acc = write_en && (!full || rd_acc).
  - When full, a simultaneous read frees a slot, so the write is taken.
- On a clk edge with rd_acc:
  - out <= mem[rd_ptr]
  - rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- On a clk edge with wr_acc:
  - mem[wr_ptr] <= in
  - wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- count next value:
  - +1 when only wr_acc
  - -1 when only rd_acc
  - unchanged when both or neither.
- Read latency: out shows the popped word in the cycle after the edge that accepted the read.
- Write-to-available latency is one cycle: available rises after the first accepted write edge.
- Empty with read_en and write_en both high:
  - the read is ignored;
  - the write is stored;
  - out is unchanged.
  - There is no fall-through bypass.
- read_en while empty: no effect; out holds its previous value.
- write_en while full without a simultaneous read: the word is dropped silently; no state changes.
- Pointer wrap-around is transparent. Data order is strictly first-in first-out across the wrap.
- No X-propagation dependence: out only changes on an accepted read or on reset.

Test Plan:
- Reset then idle: rst=1 for one edge -> out=0, available=0. read_en=1 for 3 cycles -> out stays 0, available stays 0.
- Basic order, writes then overlapping reads:
  - write 10,9,8,7 on consecutive cycles;
  - then raise read_en while continuing to write 6,5,4,3,2;
  - then drop write_en and keep read_en.
  - Required: out sequence 10,9,8,7,6,5,4,3,2, one per cycle.
  - Required: available falls after 2 is popped; out then holds 2.
  - Required: the later values 1 and 11, presented with write_en=0, are never stored.
- Fill to full: write 16 words 0x00..0x0F with no reads. A 17th write of 0xAA is dropped. Then read 17 times -> out 0x00..0x0F; the 17th read leaves out=0x0F and available=0.
- Full with simultaneous read/write: fill with 16 words, then one cycle with read_en=write_en=1 and in=0x55. Required: out=first word, count stays 16. Draining then returns the remaining 15 words followed by 0x55.
- Wrap-around: repeatedly write 5 and read 5 over 10 rounds (50 words, values 1..50). Required: out matches the input order exactly across pointer wrap.
- Reset mid-operation: store 3 words, assert rst for one edge while read_en=1. Required: available=0, out=0. A subsequent write of 0x33 followed by a read returns 0x33.
